// File: rtl/ebpc_pkg.sv
// Shared constants and types for the EBPC bit-plane symbol unpacker.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ebpc_pkg;

    localparam int EBPC_BLOCK_SIZE = 8;
    localparam int EBPC_ZRUN_W     = 3;
    localparam int EBPC_IDX_W      = $clog2(EBPC_BLOCK_SIZE - 1);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int EBPC_MAX_LEN = max_int(EBPC_BLOCK_SIZE,
                                          max_int(3 + EBPC_ZRUN_W, 5 + EBPC_IDX_W));

    // Symbol length classes, named after their bit counts
    typedef enum logic [2:0] {
        TWO,
        FIVE,
        FIVE_PLUS_LOGN,
        THREE_PLUS_LOGM,
        N
    } sym_len_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DECODE,
        ST_RUN,
        ST_DRAIN
    } unp_state_e;

endpackage

// File: rtl/ebpc_symb_unpacker_decode.sv
// Decodes one DBX/DBP symbol from the MSB-first head of the bit buffer.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to consume.
module symb_decode_comb
    import ebpc_pkg::*;
#(
    parameter int  BLOCK_SIZE = EBPC_BLOCK_SIZE,
    parameter int  ZRUN_W     = EBPC_ZRUN_W,
    localparam int DW         = BLOCK_SIZE - 1,
    localparam int IDX_W      = $clog2(DW),
    localparam int MAX_LEN    = max_int(BLOCK_SIZE, max_int(3 + ZRUN_W, 5 + IDX_W)),
    localparam int LEN_W      = $clog2(MAX_LEN + 1),
    localparam int RUN_W      = ZRUN_W + 1
) (
    input  logic [MAX_LEN-1:0] head,
    output logic [LEN_W-1:0]   len,
    output logic [DW-1:0]      dbx,
    output logic               is_dbp,
    output logic [RUN_W-1:0]   run_len,
    output logic               is_run
);

    localparam logic [DW-1:0] TWO_ONES = {2'b11, {(DW-2){1'b0}}};
    localparam logic [DW-1:0] ONE_HOT  = {1'b1, {(DW-1){1'b0}}};

    sym_len_e         cls;
    logic [IDX_W-1:0] idx;

    assign idx = head[MAX_LEN-6 -: IDX_W];

    always_comb begin
        cls     = N;
        dbx     = '0;
        is_dbp  = 1'b0;
        is_run  = 1'b0;
        run_len = '0;
        if (head[MAX_LEN-1]) begin
            dbx = head[MAX_LEN-2 -: DW];
        end else if (head[MAX_LEN-2]) begin
            cls = TWO;
        end else if (head[MAX_LEN-3]) begin
            cls     = THREE_PLUS_LOGM;
            is_run  = 1'b1;
            run_len = {1'b0, head[MAX_LEN-4 -: ZRUN_W]} + RUN_W'(1);
        end else begin
            // Two bits after the 000 prefix select the 5-bit family
            case (head[MAX_LEN-4 -: 2])
                2'b00: begin
                    cls = FIVE;
                    dbx = '1;
                end
                2'b01: begin
                    cls    = FIVE;
                    is_dbp = 1'b1;
                end
                2'b10: begin
                    cls = FIVE_PLUS_LOGN;
                    dbx = TWO_ONES >> idx;
                end
                default: begin
                    cls = FIVE_PLUS_LOGN;
                    dbx = ONE_HOT >> idx;
                end
            endcase
        end
    end

    always_comb begin
        case (cls)
            TWO:             len = LEN_W'(2);
            FIVE:            len = LEN_W'(5);
            FIVE_PLUS_LOGN:  len = LEN_W'(5 + IDX_W);
            THREE_PLUS_LOGM: len = LEN_W'(3 + ZRUN_W);
            default:         len = LEN_W'(BLOCK_SIZE);
        endcase
    end

endmodule

// File: rtl/ebpc_symb_unpacker.sv
// Streaming EBPC symbol unpacker: packed beats in, one DBX word per cycle out.
// Latency: a symbol decodes the cycle after its last bit lands; output is registered.
// Backpressure: output stall freezes decode/run; input stalls when the buffer lacks a beat of room.
module ebpc_symb_unpacker
    import ebpc_pkg::*;
#(
    parameter int  BLOCK_SIZE = EBPC_BLOCK_SIZE,
    parameter int  IN_W       = 8,
    parameter int  ZRUN_W     = EBPC_ZRUN_W,
    parameter int  CNT_W      = 16,
    localparam int DW         = BLOCK_SIZE - 1,
    localparam int IDX_W      = $clog2(DW),
    localparam int MAX_LEN    = max_int(BLOCK_SIZE, max_int(3 + ZRUN_W, 5 + IDX_W)),
    localparam int BUF_W      = 2 * max_int(IN_W, MAX_LEN),
    localparam int LEN_W      = $clog2(MAX_LEN + 1),
    localparam int FILL_W     = $clog2(BUF_W + 1),
    localparam int RUN_W      = ZRUN_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_words_i,
    output logic             busy_o,
    input  logic [IN_W-1:0]  in_data_i,
    input  logic             in_last_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [DW-1:0]    out_dbx_o,
    output logic             out_is_dbp_o,
    output logic             out_last_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             done_o,
    output logic             err_o
);

    localparam int ROOM_W = FILL_W + 1;

    unp_state_e        state;
    logic [BUF_W-1:0]  bits_q;
    logic [FILL_W-1:0] fill_q;
    logic [CNT_W-1:0]  word_cnt;
    logic [CNT_W-1:0]  num_words_q;
    logic [RUN_W-1:0]  run_cnt;
    logic              last_seen;

    logic [LEN_W-1:0]  dec_len;
    logic [DW-1:0]     dec_dbx;
    logic              dec_is_dbp;
    logic [RUN_W-1:0]  dec_run_len;
    logic              dec_is_run;

    logic              active, accept, slot_free, complete;
    logic              consume, run_emit, load, hit, underflow;
    logic [FILL_W-1:0] fill_mid, fill_nxt;
    logic [BUF_W-1:0]  bits_mid, bits_nxt;

    symb_decode_comb #(
        .BLOCK_SIZE (BLOCK_SIZE),
        .ZRUN_W     (ZRUN_W)
    ) u_decode (
        .head    (bits_q[BUF_W-1 -: MAX_LEN]),
        .len     (dec_len),
        .dbx     (dec_dbx),
        .is_dbp  (dec_is_dbp),
        .run_len (dec_run_len),
        .is_run  (dec_is_run)
    );

    assign busy_o     = (state != ST_IDLE);
    assign active     = (state == ST_DECODE) || (state == ST_RUN);
    assign in_ready_o = (state == ST_DRAIN) ||
                        (active && (ROOM_W'(fill_q) + ROOM_W'(IN_W) <= ROOM_W'(BUF_W)));
    assign accept     = in_valid_i && in_ready_o;
    assign slot_free  = !out_valid_o || out_ready_i;
    assign complete   = FILL_W'(dec_len) <= fill_q;
    assign consume    = (state == ST_DECODE) && complete && slot_free;
    assign run_emit   = (state == ST_RUN) && slot_free;
    assign load       = consume || run_emit;
    assign hit        = (word_cnt + CNT_W'(1)) == num_words_q;
    assign underflow  = (state == ST_DECODE) && last_seen && !complete;

    // Bits below fill are kept zero, so a new beat can simply be OR-ed in
    assign fill_mid = consume ? fill_q - FILL_W'(dec_len) : fill_q;
    assign bits_mid = consume ? bits_q << dec_len : bits_q;
    assign bits_nxt = accept ? bits_mid | ({in_data_i, {(BUF_W-IN_W){1'b0}}} >> fill_mid)
                             : bits_mid;
    assign fill_nxt = accept ? fill_mid + FILL_W'(IN_W) : fill_mid;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            bits_q       <= '0;
            fill_q       <= '0;
            word_cnt     <= '0;
            num_words_q  <= '0;
            run_cnt      <= '0;
            last_seen    <= 1'b0;
            out_dbx_o    <= '0;
            out_is_dbp_o <= 1'b0;
            out_last_o   <= 1'b0;
            out_valid_o  <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;

            if (load) begin
                out_valid_o  <= 1'b1;
                out_dbx_o    <= consume ? dec_dbx : '0;
                out_is_dbp_o <= consume && dec_is_dbp;
                out_last_o   <= hit;
                word_cnt     <= word_cnt + CNT_W'(1);
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end

            if (active) begin
                bits_q <= bits_nxt;
                fill_q <= fill_nxt;
            end
            if (accept && in_last_i) begin
                last_seen <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        num_words_q <= num_words_i;
                        word_cnt    <= '0;
                        run_cnt     <= '0;
                        last_seen   <= 1'b0;
                        bits_q      <= '0;
                        fill_q      <= '0;
                        state       <= (num_words_i == '0) ? ST_DRAIN : ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (consume) begin
                        if (hit) begin
                            state  <= ST_DRAIN;
                            bits_q <= '0;
                            fill_q <= '0;
                            err_o  <= dec_is_run && (dec_run_len > RUN_W'(1));
                        end else if (dec_is_run && (dec_run_len > RUN_W'(1))) begin
                            state   <= ST_RUN;
                            run_cnt <= dec_run_len - RUN_W'(1);
                        end
                    end else if (underflow) begin
                        state  <= ST_IDLE;
                        err_o  <= 1'b1;
                        done_o <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (run_emit) begin
                        run_cnt <= run_cnt - RUN_W'(1);
                        if (hit) begin
                            state  <= ST_DRAIN;
                            bits_q <= '0;
                            fill_q <= '0;
                            err_o  <= run_cnt > RUN_W'(1);
                        end else if (run_cnt == RUN_W'(1)) begin
                            state <= ST_DECODE;
                        end
                    end
                end
                default: begin
                    if (last_seen || (accept && in_last_i)) begin
                        state  <= ST_IDLE;
                        done_o <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
